seq_checker: RTL and testbench

//  Downstream consumer of the pseudo-random next_state generator in the memory game.

---
 rtl/seq_checker.sv | 186 ++++++++++++++++++
 tb/tb_seq_checker.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_checker.sv
// Memory-game sequence checker: records generator states, replays them on the display,
// then compares player guesses against the stored sequence and grows it each round.
module seq_checker #(
    parameter int unsigned W           = 6,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SHOW_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         play,
    input  logic [W-1:0] state_in,
    input  logic         guess_valid,
    input  logic [W-1:0] guess,
    output logic         show_valid,
    output logic [W-1:0] show_value,
    output logic         await_guess,
    output logic [3:0]   level,
    output logic         win,
    output logic         lose
);

    localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW,
        S_GAP,
        S_INPUT,
        S_EXTEND,
        S_WIN,
        S_LOSE
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          show_valid_q, show_valid_d;
    logic [W-1:0]  show_value_q, show_value_d;
    logic          await_q, await_d;
    logic          win_q, win_d;
    logic          lose_q, lose_d;

    logic [W-1:0]  mem_q [DEPTH];
    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic          capture_first;
    logic          at_last;
    logic          guess_match;

    assign at_last     = (4'(idx_q) == (len_q - 4'd1));
    assign guess_match = (guess == mem_q[idx_q]);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        mem_we        = 1'b0;
        mem_waddr     = '0;
        capture_first = 1'b0;

        unique case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (play) begin
                    mem_we        = 1'b1;
                    mem_waddr     = '0;
                    capture_first = 1'b1;
                    len_d         = 4'd1;
                    idx_d         = '0;
                    timer_d       = '0;
                    state_d       = S_SHOW;
                end
            end

            S_SHOW: begin
                if (timer_q == TW'(SHOW_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_GAP: begin
                if (timer_q == TW'(GAP_CYCLES - 1)) begin
                    timer_d = '0;
                    if (at_last) begin
                        idx_d   = '0;
                        state_d = S_INPUT;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_SHOW;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_INPUT: begin
                if (guess_valid) begin
                    if (!guess_match) begin
                        state_d = S_LOSE;
                    end else if (!at_last) begin
                        idx_d = idx_q + IW'(1);
                    end else if (len_q == 4'(DEPTH)) begin
                        state_d = S_WIN;
                    end else begin
                        state_d = S_EXTEND;
                    end
                end
            end

            S_EXTEND: begin
                mem_we    = 1'b1;
                mem_waddr = len_q[IW-1:0];
                len_d     = len_q + 4'd1;
                idx_d     = '0;
                timer_d   = '0;
                state_d   = S_SHOW;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are derived from the next state so they are registered yet change with it.
    // A restart writes mem[0] on the same edge, so its value is forwarded from state_in.
    always_comb begin
        show_valid_d = (state_d == S_SHOW);
        show_value_d = '0;
        if (state_d == S_SHOW) begin
            show_value_d = capture_first ? state_in : mem_q[idx_d];
        end
        await_d = (state_d == S_INPUT);
        win_d   = (state_d == S_WIN);
        lose_d  = (state_d == S_LOSE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            show_valid_q <= 1'b0;
            show_value_q <= '0;
            await_q      <= 1'b0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            show_valid_q <= show_valid_d;
            show_value_q <= show_value_d;
            await_q      <= await_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
        end
    end

    // NOTE: the sequence buffer has no reset; entries are always written before they are
    // read, and leaving it unreset lets it map onto plain storage.
    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= state_in;
        end
    end

    assign show_valid  = show_valid_q;
    assign show_value  = show_value_q;
    assign await_guess = await_q;
    assign level       = len_q;
    assign win         = win_q;
    assign lose        = lose_q;

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: a scoreboard of expected presented entries
// is filled when a round starts and drained as the display shows them.
module tb_seq_checker;

    localparam int W           = 6;
    localparam int DEPTH       = 8;
    localparam int SHOW_CYCLES = 4;
    localparam int GAP_CYCLES  = 2;
    localparam int STEP_LIMIT  = 400;

    logic         clk_in = 1'b0;
    logic         rst_n;
    logic         play;
    logic [W-1:0] state_in;
    logic         guess_valid;
    logic [W-1:0] guess;
    logic         show_valid;
    logic [W-1:0] show_value;
    logic         await_guess;
    logic [3:0]   level;
    logic         win;
    logic         lose;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] show_q [$];
    logic [W-1:0] exp_seq [DEPTH];
    int           exp_len;
    logic         prev_sv;
    logic [W-1:0] cur_exp;
    int           run_len;

    seq_checker #(
        .W(W), .DEPTH(DEPTH), .SHOW_CYCLES(SHOW_CYCLES), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .play       (play),
        .state_in   (state_in),
        .guess_valid(guess_valid),
        .guess      (guess),
        .show_valid (show_valid),
        .show_value (show_value),
        .await_guess(await_guess),
        .level      (level),
        .win        (win),
        .lose       (lose)
    );

    always #5 clk_in = ~clk_in;

    // One clock, then drain/compare the scoreboard against what the display shows.
    task automatic step();
        @(posedge clk_in);
        #1;
        if (show_valid && !prev_sv) begin
            checks++;
            if (show_q.size() == 0) begin
                errors++;
                $display("FAIL show_unexpected: value %h presented, none expected", show_value);
                cur_exp = show_value;
            end else begin
                cur_exp = show_q.pop_front();
                if (show_value !== cur_exp) begin
                    errors++;
                    $display("FAIL show_value: got %h expected %h", show_value, cur_exp);
                end
            end
            run_len = 1;
        end else if (show_valid) begin
            run_len++;
            checks++;
            if (show_value !== cur_exp) begin
                errors++;
                $display("FAIL show_hold: got %h expected %h", show_value, cur_exp);
            end
        end else begin
            checks++;
            if (show_value !== '0) begin
                errors++;
                $display("FAIL show_blank: got %h expected 00", show_value);
            end
            if (prev_sv) begin
                checks++;
                if (run_len !== SHOW_CYCLES) begin
                    errors++;
                    $display("FAIL show_len: got %0d cycles expected %0d", run_len, SHOW_CYCLES);
                end
            end
        end
        prev_sv = show_valid;
    endtask

    task automatic push_replay();
        for (int i = 0; i < exp_len; i++) show_q.push_back(exp_seq[i]);
    endtask

    task automatic do_play(input logic [W-1:0] s);
        state_in = s;
        play     = 1'b1;
        step();
        play     = 1'b0;
    endtask

    task automatic do_guess(input logic [W-1:0] g, input logic [W-1:0] s);
        state_in    = s;
        guess       = g;
        guess_valid = 1'b1;
        step();
        guess_valid = 1'b0;
    endtask

    // Steps until await_guess rises; with noise, play and a wrong guess are pulsed meanwhile.
    task automatic wait_await(input int expected, input logic noise, input string name);
        int n = 0;
        while (!await_guess && n < STEP_LIMIT) begin
            if (noise) begin
                play        = 1'b1;
                guess_valid = 1'b1;
                guess       = exp_seq[0] ^ 6'h3F;
            end
            step();
            n++;
        end
        play        = 1'b0;
        guess_valid = 1'b0;
        checks++;
        if (n !== expected) begin
            errors++;
            $display("FAIL %s: await after %0d cycles expected %0d", name, n, expected);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b1;
        play        = 1'b0;
        guess_valid = 1'b0;
        state_in    = '0;
        guess       = '0;
        prev_sv     = 1'b0;
        run_len     = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({show_valid, show_value, await_guess, level, win, lose} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b expected 0",
                     {show_valid, show_value, await_guess, level, win, lose});
        end
        @(negedge clk_in) rst_n = 1'b1;

        exp_seq[0] = 6'h2A;
        exp_len    = 1;
        push_replay();
        do_play(6'h2A);
        step();
        checks++;
        if (show_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_show: show_valid %b expected 1", show_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({show_valid, show_value, await_guess, level, win, lose} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b expected 0",
                     {show_valid, show_value, await_guess, level, win, lose});
        end
        prev_sv = 1'b0;
        @(negedge clk_in) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({show_valid, await_guess, level, win, lose} !== '0) begin
                errors++;
                $display("FAIL idle_after_reset: got %b expected 0",
                         {show_valid, await_guess, level, win, lose});
            end
        end
    endtask

    task automatic test_first_round();
        exp_seq[0] = 6'h2A;
        exp_len    = 1;
        push_replay();
        do_play(6'h2A);
        checks++;
        if (show_valid !== 1'b1 || level !== 4'd1) begin
            errors++;
            $display("FAIL play_latency: show_valid %b level %0d expected 1 and 1", show_valid, level);
        end
        wait_await(SHOW_CYCLES + GAP_CYCLES, 1'b0, "first_round");
        checks++;
        if (level !== 4'd1 || show_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_level: level %0d show_valid %b expected 1 and 0", level, show_valid);
        end
    endtask

    task automatic test_extend();
        do_guess(6'h2A, 6'h15);
        checks++;
        if (await_guess !== 1'b0 || lose !== 1'b0) begin
            errors++;
            $display("FAIL extend_enter: await %b lose %b expected 0 and 0", await_guess, lose);
        end
        exp_seq[exp_len] = 6'h15;
        exp_len++;
        push_replay();
        wait_await(exp_len * (SHOW_CYCLES + GAP_CYCLES) + 1, 1'b0, "extend_replay");
        checks++;
        if (level !== 4'd2) begin
            errors++;
            $display("FAIL extend_level: got %0d expected 2", level);
        end
    endtask

    task automatic test_ignore();
        do_play(6'h3F);
        checks++;
        if (await_guess !== 1'b1 || show_valid !== 1'b0 || level !== 4'd2) begin
            errors++;
            $display("FAIL play_in_input: await %b show %b level %0d expected 1 0 2",
                     await_guess, show_valid, level);
        end
        do_guess(exp_seq[0], 6'h0C);
        checks++;
        if (await_guess !== 1'b1 || lose !== 1'b0) begin
            errors++;
            $display("FAIL mid_guess: await %b lose %b expected 1 and 0", await_guess, lose);
        end
        do_guess(exp_seq[1], 6'h0C);
        exp_seq[exp_len] = 6'h0C;
        exp_len++;
        push_replay();
        wait_await(exp_len * (SHOW_CYCLES + GAP_CYCLES) + 1, 1'b1, "noise_replay");
        checks++;
        if (level !== 4'd3 || lose !== 1'b0) begin
            errors++;
            $display("FAIL noise_level: level %0d lose %b expected 3 and 0", level, lose);
        end
    endtask

    task automatic test_lose();
        do_guess(6'h00, 6'h11);
        checks++;
        if (lose !== 1'b1 || await_guess !== 1'b0) begin
            errors++;
            $display("FAIL lose_set: lose %b await %b expected 1 and 0", lose, await_guess);
        end
        for (int i = 0; i < 3; i++) begin
            do_guess(exp_seq[0], 6'h11);
            checks++;
            if (lose !== 1'b1 || await_guess !== 1'b0 || show_valid !== 1'b0 || level !== 4'd3) begin
                errors++;
                $display("FAIL lose_sticky: lose %b await %b show %b level %0d expected 1 0 0 3",
                         lose, await_guess, show_valid, level);
            end
        end
        exp_seq[0] = 6'h07;
        exp_len    = 1;
        push_replay();
        do_play(6'h07);
        checks++;
        if (lose !== 1'b0 || level !== 4'd1) begin
            errors++;
            $display("FAIL lose_restart: lose %b level %0d expected 0 and 1", lose, level);
        end
        wait_await(SHOW_CYCLES + GAP_CYCLES, 1'b0, "restart_round");
    endtask

    task automatic test_win();
        logic [W-1:0] nxt;
        int           pre;
        int           rounds;
        rounds = DEPTH - exp_len + 1;
        for (int r = 0; r < rounds; r++) begin
            pre = exp_len;
            nxt = '0;
            for (int i = 0; i < pre; i++) begin
                nxt = W'($urandom_range(0, 63));
                do_guess(exp_seq[i], nxt);
                if (i < pre - 1) begin
                    checks++;
                    if (await_guess !== 1'b1 || lose !== 1'b0) begin
                        errors++;
                        $display("FAIL win_mid_guess: await %b lose %b expected 1 and 0",
                                 await_guess, lose);
                    end
                end
            end
            if (pre < DEPTH) begin
                exp_seq[exp_len] = nxt;
                exp_len++;
                push_replay();
                wait_await(exp_len * (SHOW_CYCLES + GAP_CYCLES) + 1, 1'b0, "win_round");
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (win !== 1'b1 || lose !== 1'b0 || await_guess !== 1'b0 || show_valid !== 1'b0 ||
                level !== 4'(DEPTH)) begin
                errors++;
                $display("FAIL win_state: win %b lose %b await %b show %b level %0d expected 1 0 0 0 %0d",
                         win, lose, await_guess, show_valid, level, DEPTH);
            end
            do_guess(exp_seq[0] ^ 6'h01, 6'h22);
        end
        exp_seq[0] = 6'h22;
        exp_len    = 1;
        push_replay();
        do_play(6'h22);
        checks++;
        if (win !== 1'b0 || level !== 4'd1 || show_valid !== 1'b1) begin
            errors++;
            $display("FAIL win_restart: win %b level %0d show %b expected 0 1 1", win, level, show_valid);
        end
        wait_await(SHOW_CYCLES + GAP_CYCLES, 1'b0, "win_restart_round");
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_extend();
        test_ignore();
        test_lose();
        test_win();
        checks++;
        if (show_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", show_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
